// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 registered stream multiplexer.
package mux_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches ptr+1 .. ptr (mod CHANNELS), owns the ptr register.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                enable,
  input  logic                advance,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  logic [SEL_W-1:0] ptr_q;

  // Walk the search order backwards so the earliest hit (closest after ptr) wins.
  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned k = CHANNELS; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % CHANNELS;
      if (req[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
    grant_valid = grant_valid & enable;
  end

  // Pointer moves to the last granted channel; reset value gives channel 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SEL_W'(CHANNELS - 1);
    end else if (advance) begin
      ptr_q <= grant;
    end
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-to-1 registered stream multiplexer with fixed-select or round-robin arbitration.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic             rr_mode;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;
  logic [SEL_W-1:0] fix_grant;
  logic             fix_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_ok;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  assign rr_mode = (mux_mode_t'(mode) == MUX_RR);

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (in_valid),
    .enable     (rr_mode),
    .advance    (rr_mode && xfer),
    .grant      (rr_grant),
    .grant_valid(rr_valid)
  );

  // Fixed select: out-of-range sel values simply never match a channel.
  always_comb begin
    fix_grant = '0;
    fix_valid = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        fix_grant = SEL_W'(i);
        fix_valid = 1'b1;
      end
    end
  end

  // Final grant, handshake and data select; in_ready held low during reset.
  always_comb begin
    grant       = rr_mode ? rr_grant : fix_grant;
    grant_valid = rr_mode ? rr_valid : fix_valid;
    load_ok     = !out_valid || out_ready;
    in_ready    = '0;
    sel_data    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = grant_valid && load_ok && rst_n;
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
    xfer = |(in_valid & in_ready);
  end

  // Output register: load on input transfer, otherwise drain on output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
